// File: rtl/stepper_pulse_gen.sv
// Step/direction generator with trapezoidal accel/decel; first pul rise DIR_SETUP clocks after enable is sampled.
// Stops and reversals always decelerate to standstill first; command inputs are only looked at on step boundaries.
module stepper_pulse_gen #(
  parameter int unsigned PERIOD_START = 200_000,
  parameter int unsigned PERIOD_MIN   = 20_000,
  parameter int unsigned ACCEL_STEP   = 2_000,
  parameter int unsigned PULSE_W      = 500,
  parameter int unsigned DIR_SETUP    = 1_000
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        enable,
  input  logic        direct,
  output logic        pul,
  output logic        dir,
  output logic        ena_n,
  output logic        busy,
  output logic [31:0] position
);

  localparam int unsigned SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(DIR_SETUP - 1);
  localparam logic [23:0] P_START = 24'(PERIOD_START);
  localparam logic [23:0] P_MIN   = 24'(PERIOD_MIN);
  localparam logic [24:0] ACC     = 25'(ACCEL_STEP);
  localparam logic [23:0] PW_LAST = 24'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DECEL} state_t;

  state_t             state_q, state_d;
  logic [23:0]        period_q, period_d;
  logic [23:0]        timer_q, timer_d;
  logic [SETUP_W-1:0] setup_q, setup_d;
  logic               pul_q, pul_d;
  logic               dir_q, dir_d;
  logic [31:0]        pos_q, pos_d;

  logic [24:0] period_up;
  logic [23:0] period_dec;
  logic        boundary;
  logic        want_stop;
  logic        step_start;

  // 25-bit sum so the standstill test cannot wrap near the 24-bit ceiling.
  assign period_up  = {1'b0, period_q} + ACC;
  assign period_dec = ({1'b0, period_q} >= ({1'b0, P_MIN} + ACC)) ? (period_q - ACC[23:0]) : P_MIN;
  assign boundary   = ((state_q == RUN) || (state_q == DECEL)) && (timer_q == (period_q - 24'd1));
  assign want_stop  = !enable || (direct != dir_q);

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    timer_d    = timer_q;
    setup_d    = setup_q;
    pul_d      = pul_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    step_start = 1'b0;

    if (pul_q && (timer_q == PW_LAST)) begin
      pul_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = SETUP;
          dir_d    = direct;
          period_d = P_START;
          setup_d  = '0;
        end
      end
      SETUP: begin
        if (setup_q == SETUP_LAST) begin
          state_d    = RUN;
          step_start = 1'b1;
        end else begin
          setup_d = setup_q + 1'b1;
        end
      end
      RUN, DECEL: begin
        if (!boundary) begin
          timer_d = timer_q + 24'd1;
        end else if (!want_stop) begin
          period_d   = period_dec;
          state_d    = RUN;
          step_start = 1'b1;
        end else if (period_up <= {1'b0, P_START}) begin
          period_d   = period_up[23:0];
          state_d    = DECEL;
          step_start = 1'b1;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          // Reversal at standstill: new direction gets a fresh setup window.
          state_d  = SETUP;
          dir_d    = direct;
          period_d = P_START;
          setup_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (step_start) begin
      timer_d = '0;
      pul_d   = 1'b1;
      pos_d   = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
    end
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q  <= IDLE;
      period_q <= P_START;
      timer_q  <= '0;
      setup_q  <= '0;
      pul_q    <= 1'b0;
      dir_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      setup_q  <= setup_d;
      pul_q    <= pul_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
    end
  end

  assign pul      = pul_q;
  assign dir      = dir_q;
  assign ena_n    = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign position = pos_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen with small timing parameters (20/8/4/3/5).
module tb_stepper_pulse_gen;

  logic        sclk;
  logic        s_rst;
  logic        enable;
  logic        direct;
  logic        pul;
  logic        dir;
  logic        ena_n;
  logic        busy;
  logic [31:0] position;

  int total;
  int bad;
  int n;

  stepper_pulse_gen #(
    .PERIOD_START(20),
    .PERIOD_MIN  (8),
    .ACCEL_STEP  (4),
    .PULSE_W     (3),
    .DIR_SETUP   (5)
  ) dut (
    .sclk    (sclk),
    .s_rst   (s_rst),
    .enable  (enable),
    .direct  (direct),
    .pul     (pul),
    .dir     (dir),
    .ena_n   (ena_n),
    .busy    (busy),
    .position(position)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc1();
  endtask

  // Cycles until pul is seen high; -1 if it never rises within the budget.
  task automatic next_rise(output int c);
    c = -1;
    for (int i = 1; i <= 64; i++) begin
      cyc1();
      if (pul === 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  // Called just after a step start: measures pulse width and distance to the next step start.
  task automatic meas(output int per, output int wid);
    per = -1;
    wid = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc1();
      if (wid == 0 && pul === 1'b0) wid = i;
      if (wid != 0 && pul === 1'b1) begin
        per = i;
        break;
      end
    end
  endtask

  task automatic check_step(input string tag, input int exp_per, input int exp_pos);
    int per;
    int wid;
    meas(per, wid);
    chk({tag, " period"}, per, exp_per);
    chk({tag, " width"}, wid, 3);
    chk({tag, " position"}, position, exp_pos);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    s_rst  = 1'b1;
    enable = 1'b0;
    direct = 1'b0;
    cycles(2);

    // Reset values
    chk("rst pul", pul, 0);
    chk("rst dir", dir, 0);
    chk("rst ena_n", ena_n, 1);
    chk("rst busy", busy, 0);
    chk("rst position", position, 0);

    s_rst = 1'b0;
    cycles(3);
    chk("idle busy", busy, 0);

    // Acceleration from standstill, clockwise
    enable = 1'b1;
    direct = 1'b1;
    cyc1();
    chk("e0 dir", dir, 1);
    chk("e0 ena_n", ena_n, 0);
    chk("e0 busy", busy, 1);
    next_rise(n);
    chk("first rise delay", n, 5);
    chk("first position", position, 1);
    check_step("acc1", 20, 2);
    check_step("acc2", 16, 3);
    check_step("acc3", 12, 4);
    check_step("acc4", 8, 5);
    check_step("acc5", 8, 6);

    // Stop request during a period-8 step
    enable = 1'b0;
    check_step("stop1", 8, 7);
    check_step("stop2", 12, 8);
    check_step("stop3", 16, 9);
    cycles(19);
    chk("stop busy before end", busy, 1);
    cyc1();
    chk("stop busy", busy, 0);
    chk("stop ena_n", ena_n, 1);
    chk("stop position", position, 9);
    next_rise(n);
    chk("stop no pulse", n, -1);
    chk("stop frozen position", position, 9);

    // Reversal at top speed
    enable = 1'b1;
    direct = 1'b1;
    cyc1();
    next_rise(n);
    chk("rev first rise", n, 5);
    check_step("rev acc1", 20, 11);
    check_step("rev acc2", 16, 12);
    check_step("rev acc3", 12, 13);
    check_step("rev acc4", 8, 14);
    direct = 1'b0;
    check_step("rev dec1", 8, 15);
    chk("rev dec1 dir", dir, 1);
    check_step("rev dec2", 12, 16);
    check_step("rev dec3", 16, 17);
    chk("rev dec3 dir", dir, 1);
    cycles(19);
    chk("rev dir held", dir, 1);
    cyc1();
    chk("rev dir flipped", dir, 0);
    chk("rev busy", busy, 1);
    next_rise(n);
    chk("rev setup delay", n, 5);
    chk("rev first position", position, 16);
    check_step("ccw1", 20, 15);
    check_step("ccw2", 16, 14);
    check_step("ccw3", 12, 13);
    check_step("ccw4", 8, 12);

    // Command restored mid-deceleration
    enable = 1'b0;
    check_step("resume dec1", 8, 11);
    check_step("resume dec2", 12, 10);
    enable = 1'b1;
    check_step("resume1", 16, 9);
    check_step("resume2", 12, 8);
    check_step("resume3", 8, 7);
    check_step("resume4", 8, 6);
    chk("resume dir", dir, 0);
    chk("resume busy", busy, 1);

    // Reset in the second cycle of a pulse
    cyc1();
    chk("pre-reset pul", pul, 1);
    s_rst = 1'b1;
    #1;
    chk("mid rst pul", pul, 0);
    chk("mid rst position", position, 0);
    chk("mid rst ena_n", ena_n, 1);
    chk("mid rst dir", dir, 0);
    enable = 1'b0;
    cyc1();
    s_rst = 1'b0;
    cycles(10);
    chk("post rst busy", busy, 0);
    chk("post rst pul", pul, 0);
    enable = 1'b1;
    direct = 1'b1;
    cyc1();
    chk("restart busy", busy, 1);
    next_rise(n);
    chk("restart rise delay", n, 5);
    chk("restart position", position, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
